// File: rtl/display_pkg.sv
// display_pkg: shared types and constants for the multiplexed 7-segment driver.
//   seg_t      : 7-bit active-low segment vector {a,b,c,d,e,f,g}
//   code_t     : 4-bit character code
//   CODE_*     : non-numeric character codes
//   SEG_OFF    : all segments dark
//   err_code() : character shown on a given digit while the "Erro" override is active
package display_pkg;

    typedef logic [6:0] seg_t;
    typedef logic [3:0] code_t;

    localparam code_t CODE_BLANK = 4'b1010;
    localparam code_t CODE_E     = 4'b1011;
    localparam code_t CODE_R     = 4'b1100;
    localparam code_t CODE_O     = 4'b1101;
    localparam code_t CODE_A     = 4'b1110;
    localparam code_t CODE_F     = 4'b1111;

    localparam seg_t SEG_OFF = 7'b1111111;

    // "Erro" reads left to right on digits 3..0; wider displays pad with blanks.
    function automatic code_t err_code(input int unsigned idx);
        case (idx)
            0:       err_code = CODE_O;
            1, 2:    err_code = CODE_R;
            3:       err_code = CODE_E;
            default: err_code = CODE_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seven_segment_rom.sv
// seven_segment_rom: combinational 4-bit character code to active-low segments.
//   code : character code (0-9, blank, E, r, o, A, F)
//   seg  : {a,b,c,d,e,f,g}, 0 lights the segment
module seven_segment_rom
    import display_pkg::*;
(
    input  code_t code,
    output seg_t  seg
);

    always_comb begin
        seg = SEG_OFF;
        case (code)
            4'd0:   seg = 7'b0000001;
            4'd1:   seg = 7'b1001111;
            4'd2:   seg = 7'b0010010;
            4'd3:   seg = 7'b0000110;
            4'd4:   seg = 7'b1001100;
            4'd5:   seg = 7'b0100100;
            4'd6:   seg = 7'b0100000;
            4'd7:   seg = 7'b0001111;
            4'd8:   seg = 7'b0000000;
            4'd9:   seg = 7'b0000100;
            CODE_E: seg = 7'b0110000;
            CODE_R: seg = 7'b1111010;
            CODE_O: seg = 7'b1100010;
            CODE_A: seg = 7'b0001000;
            CODE_F: seg = 7'b0111000;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/multiplexed_display_driver.sv
// multiplexed_display_driver: time-multiplexed common-anode 7-segment driver.
// A loaded word is held in `pending` and only copied into `shown` at a frame
// boundary, so a frame never mixes digits from two different words.
//   clock      : system clock, rising edge
//   reset      : asynchronous, active-high
//   load       : one-cycle strobe capturing `value`
//   value      : packed 4-bit codes, digit 0 in [3:0]
//   error      : level; while high the display reads "Erro"
//   seg        : active-low {a,b,c,d,e,f,g}, registered
//   an         : active-low one-hot digit enable, registered
//   frame_done : one-cycle pulse as the scan wraps to digit 0
// Optional: define DISPLAY_LZS_EN for leading-zero suppression.
module multiplexed_display_driver
    import display_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  error,
    output seg_t                  seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = $clog2(DIGITS);

    logic [DIV_W-1:0]           div_cnt;
    logic [IDX_W-1:0]           digit_idx;
    logic [DIGITS-1:0][3:0]     shown;
    logic [DIGITS-1:0][3:0]     pending;
    logic                       pend_valid;

    logic  tc;
    logic  boundary;
    code_t disp_code;
    seg_t  rom_seg;

    assign tc       = (div_cnt == DIV_W'(SCAN_DIV - 1));
    assign boundary = tc && (digit_idx == IDX_W'(DIGITS - 1));

    // Scan position
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_cnt   <= '0;
            digit_idx <= '0;
        end else if (tc) begin
            div_cnt   <= '0;
            digit_idx <= (digit_idx == IDX_W'(DIGITS - 1)) ? '0 : digit_idx + 1'b1;
        end else begin
            div_cnt   <= div_cnt + 1'b1;
        end
    end

    // Double-buffered word. A load landing on the boundary cycle bypasses
    // `pending` so it is not delayed by a whole extra frame.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shown      <= {DIGITS{CODE_BLANK}};
            pending    <= {DIGITS{CODE_BLANK}};
            pend_valid <= 1'b0;
        end else if (boundary) begin
            if (load) begin
                shown      <= value;
                pending    <= value;
                pend_valid <= 1'b0;
            end else if (pend_valid) begin
                shown      <= pending;
                pend_valid <= 1'b0;
            end
        end else if (load) begin
            pending    <= value;
            pend_valid <= 1'b1;
        end
    end

`ifdef DISPLAY_LZS_EN
    // lz_blank[i]: digit i and every digit above it are code 0000.
    logic [DIGITS-1:0] lz_blank;
    logic              all_zero;
    always_comb begin
        lz_blank = '0;
        all_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            all_zero    = all_zero && (shown[i] == 4'd0);
            lz_blank[i] = all_zero;
        end
    end
`endif

    always_comb begin
        disp_code = shown[digit_idx];
`ifdef DISPLAY_LZS_EN
        if (lz_blank[digit_idx]) disp_code = CODE_BLANK;
`endif
        if (error) disp_code = err_code(32'(digit_idx));
    end

    seven_segment_rom u_rom (
        .code (disp_code),
        .seg  (rom_seg)
    );

    // Anodes go dark on the first cycle of each slot so the previous digit's
    // segments never bleed onto the next digit while seg settles.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seg        <= SEG_OFF;
            an         <= '1;
            frame_done <= 1'b0;
        end else begin
            seg        <= rom_seg;
            an         <= (div_cnt == '0) ? '1 : ~(DIGITS'(1) << digit_idx);
            frame_done <= boundary;
        end
    end

endmodule

// File: tb/tb_multiplexed_display_driver.sv
module tb_multiplexed_display_driver;

    localparam int D  = 4;
    localparam int SD = 4;
    localparam int FR = D * SD;

    logic          clock, reset, load, error;
    logic [15:0]   value;
    logic [6:0]    seg;
    logic [3:0]    an;
    logic          frame_done;

    multiplexed_display_driver #(.DIGITS(D), .SCAN_DIV(SD)) dut (
        .clock(clock), .reset(reset), .load(load), .value(value),
        .error(error), .seg(seg), .an(an), .frame_done(frame_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int pass_cnt = 0;
    int total    = 0;

    // Which segments each code lights, as letters a..g.
    string lit [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg",
                        "abc", "abcdefg", "abcdfg", "", "adefg", "eg", "cdeg",
                        "abcefg", "aefg"};
    string err_lit [4] = '{"cdeg", "eg", "eg", "adefg"};   // digit 0..3: o r r E

    // Reference model: time since reset plus the two words.
    int          t;
    logic [15:0] m_shown, m_pend;
    bit          m_pv;
    logic [6:0]  exp_seg;
    logic [3:0]  exp_an;
    logic        exp_fd;

    function automatic logic [6:0] seg_from(input string s);
        logic [6:0] v;
        v = 7'h7F;
        for (int i = 0; i < s.len(); i++) v[6 - (s[i] - "a")] = 1'b0;
        return v;
    endfunction

    function automatic logic [6:0] model_seg(input int dig);
        logic [3:0] c;
        if (error) return (dig < 4) ? seg_from(err_lit[dig]) : 7'h7F;
        c = m_shown[4*dig +: 4];
`ifdef DISPLAY_LZS_EN
        if (dig > 0 && (m_shown >> (4*dig)) == 16'd0) return 7'h7F;
`endif
        return seg_from(lit[c]);
    endfunction

    task automatic model_reset();
        t = 0; m_shown = 16'hAAAA; m_pend = 16'hAAAA; m_pv = 0;
    endtask

    // Advance one clock; exp_* describe the outputs registered on that edge.
    task automatic tick();
        int div, dig;
        bit bnd;
        div = t % SD;
        dig = (t / SD) % D;
        bnd = (t % FR) == FR - 1;
        exp_an  = (div == 0) ? 4'hF : ~(4'b0001 << dig);
        exp_seg = model_seg(dig);
        exp_fd  = bnd;
        if (bnd) begin
            if (load) begin m_shown = value; m_pv = 0; end
            else if (m_pv) begin m_shown = m_pend; m_pv = 0; end
        end else if (load) begin
            m_pend = value; m_pv = 1;
        end
        t++;
        @(posedge clock); #1;
        load = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] an_plan;
        total++; if (seg !== 7'h7F) $display("FAIL reset_seg got %b want 1111111", seg); else pass_cnt++;
        total++; if (an !== 4'hF) $display("FAIL reset_an got %b want 1111", an); else pass_cnt++;
        total++; if (frame_done !== 1'b0) $display("FAIL reset_fd got %b want 0", frame_done); else pass_cnt++;
        for (int k = 1; k <= 16; k++) begin
            tick();
            an_plan = ((k - 1) % 4 == 0) ? 4'hF : ~(4'b0001 << ((k - 1) / 4));
            total++;
            if (seg !== 7'h7F || an !== an_plan || frame_done !== (k == 16))
                $display("FAIL scan16 cycle %0d got seg=%b an=%b fd=%b want seg=1111111 an=%b fd=%b",
                         k, seg, an, frame_done, an_plan, k == 16);
            else pass_cnt++;
        end
    endtask

    task automatic test_load_midframe();
        int pos;
        while (t % FR != 5) tick();
        load = 1'b1; value = 16'h1234;
        while (t % FR != 0) begin
            pos = t;
            tick();
            total++;
            if (seg !== exp_seg || an !== exp_an || (an != 4'hF && seg !== 7'h7F))
                $display("FAIL midframe_blank t=%0d got seg=%b an=%b want seg=%b an=%b", pos, seg, an, exp_seg, exp_an);
            else pass_cnt++;
        end
        repeat (FR) begin
            tick();
            total++;
            if (seg !== exp_seg || an !== exp_an || frame_done !== exp_fd ||
                (an == 4'b1110 && seg !== 7'b1001100) || (an == 4'b0111 && seg !== 7'b1001111))
                $display("FAIL load1234 got seg=%b an=%b fd=%b want seg=%b an=%b fd=%b",
                         seg, an, frame_done, exp_seg, exp_an, exp_fd);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] want = 16'h5678;
        logic [6:0]  ds;
        int          dig;
        while (t % FR != 3) tick();
        load = 1'b1; value = 16'h1234; tick();
        tick();
        load = 1'b1; value = 16'h5678;
        while (t % FR != 0) tick();
        repeat (FR) begin
            dig = (t / SD) % D;
            tick();
            ds = seg_from(lit[want[4*dig +: 4]]);
            total++;
            if (seg !== exp_seg || an !== exp_an || (an != 4'hF && seg !== ds))
                $display("FAIL back_to_back digit %0d got seg=%b an=%b want seg=%b an=%b", dig, seg, an, ds, exp_an);
            else pass_cnt++;
        end
    endtask

    task automatic test_error();
        logic [6:0] ev [4] = '{7'b1100010, 7'b1111010, 7'b1111010, 7'b0110000};
        int dig;
        load = 1'b1; value = 16'h0042; tick();
        while (t % FR != 0) tick();
        repeat (5) tick();
        dig = (t / SD) % D;
        error = 1'b1;
        tick();
        total++;
        if (seg !== ev[dig]) $display("FAIL error_1cycle got seg=%b want %b", seg, ev[dig]); else pass_cnt++;
        repeat (FR) begin
            dig = (t / SD) % D;
            tick();
            total++;
            if (seg !== exp_seg || an !== exp_an || seg !== ev[dig])
                $display("FAIL error_frame digit %0d got seg=%b an=%b want seg=%b an=%b", dig, seg, an, ev[dig], exp_an);
            else pass_cnt++;
        end
        error = 1'b0;
        repeat (FR) begin
            tick();
            total++;
            if (seg !== exp_seg || an !== exp_an || frame_done !== exp_fd)
                $display("FAIL error_release got seg=%b an=%b fd=%b want seg=%b an=%b fd=%b",
                         seg, an, frame_done, exp_seg, exp_an, exp_fd);
            else pass_cnt++;
        end
    endtask

`ifdef DISPLAY_LZS_EN
    task automatic test_lzs();
        logic [6:0] w40 [4] = '{7'b0000001, 7'b1001100, 7'h7F, 7'h7F};
        logic [6:0] w00 [4] = '{7'b0000001, 7'h7F, 7'h7F, 7'h7F};
        int dig;
        load = 1'b1; value = 16'h0040; tick();
        while (t % FR != 0) tick();
        repeat (FR) begin
            dig = (t / SD) % D; tick(); total++;
            if (seg !== exp_seg || (an != 4'hF && seg !== w40[dig]))
                $display("FAIL lzs_0040 digit %0d got seg=%b want %b", dig, seg, w40[dig]);
            else pass_cnt++;
        end
        load = 1'b1; value = 16'h0000; tick();
        while (t % FR != 0) tick();
        repeat (FR) begin
            dig = (t / SD) % D; tick(); total++;
            if (seg !== exp_seg || (an != 4'hF && seg !== w00[dig]))
                $display("FAIL lzs_0000 digit %0d got seg=%b want %b", dig, seg, w00[dig]);
            else pass_cnt++;
        end
    endtask
`endif

    task automatic test_async_reset();
        load = 1'b1; value = 16'h9999; tick();
        while (t % FR != 0) tick();
        while (t % FR != 10) tick();   // state now: digit 2, mid-slot
        #2 reset = 1'b1;
        #1;
        total++;
        if (seg !== 7'h7F || an !== 4'hF || frame_done !== 1'b0)
            $display("FAIL async_reset got seg=%b an=%b fd=%b want 1111111 1111 0", seg, an, frame_done);
        else pass_cnt++;
        @(posedge clock); #2;
        reset = 1'b0;
        model_reset();
        tick();
        total++;
        if (seg !== 7'h7F || an !== 4'hF) $display("FAIL post_reset_c1 got seg=%b an=%b want 1111111 1111", seg, an);
        else pass_cnt++;
        tick();
        total++;
        if (seg !== 7'h7F || an !== 4'b1110) $display("FAIL post_reset_c2 got seg=%b an=%b want 1111111 1110", seg, an);
        else pass_cnt++;
        repeat (FR) begin
            tick(); total++;
            if (seg !== exp_seg || an !== exp_an || frame_done !== exp_fd)
                $display("FAIL post_reset got seg=%b an=%b fd=%b want seg=%b an=%b fd=%b",
                         seg, an, frame_done, exp_seg, exp_an, exp_fd);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        repeat (800) begin
            if ($urandom_range(0, 19) == 0) begin load = 1'b1; value = 16'($urandom); end
            if ($urandom_range(0, 39) == 0) error = ~error;
            tick();
            total++;
            if (seg !== exp_seg || an !== exp_an || frame_done !== exp_fd)
                $display("FAIL random t=%0d got seg=%b an=%b fd=%b want seg=%b an=%b fd=%b",
                         t - 1, seg, an, frame_done, exp_seg, exp_an, exp_fd);
            else pass_cnt++;
        end
        error = 1'b0;
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; error = 1'b0; value = 16'h0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        model_reset();
        test_reset();
        test_load_midframe();
        test_back_to_back();
        test_error();
`ifdef DISPLAY_LZS_EN
        test_lzs();
`endif
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/multiplexed_display_driver.md
# multiplexed_display_driver

Time-multiplexed driver for a common-anode multi-digit 7-segment display in the timer path. Latches a packed BCD/character word through a load strobe, applies it at frame boundaries to avoid tearing, scans one digit per prescaler period, and can override the display with the word "Erro". It replaces per-digit static decoders with one shared decoder and one set of segment lines.

## Interface
- `DIGITS`, 4: number of digits; legal range 4..8.
- `SCAN_DIV`, 50000: clock cycles per digit slot; must be at least 2.
- `clock`  in  1: system clock, rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `load`  in  1: single-cycle strobe; captures `value`.
- `value`  in  4*DIGITS: packed 4-bit codes; digit 0 is in bits [3:0].
- `error`  in  1: level signal; while high, the display shows "Erro".
- `seg`  out  7: {a,b,c,d,e,f,g}; active-low (0 lights the segment).
- `an`  out  DIGITS: one-hot digit enable; active-low.
- `frame_done`  out  1: one-cycle pulse when the scan wraps from digit DIGITS-1 to digit 0.

## Operation
- Character codes:
  - 0000–1001: digits 0–9.
  - 1010: blank, all segments off.
  - 1011: E. 1100: r. 1101: o. 1110: A. 1111: F.
- Prescaler `div_cnt` counts 0..SCAN_DIV-1 and wraps. At terminal count, `digit_idx` increments and wraps DIGITS-1 to 0.
- Load path:
  - `load` writes `value` into the `pending` register and sets `pend_valid`.
  - A later `load` before the frame boundary overwrites `pending`; the latest value wins.
- Frame boundary: the cycle where `div_cnt` is at terminal and `digit_idx` is DIGITS-1.
  - If `pend_valid` is set, `shown` takes `pending` and `pend_valid` clears.
  - If `load` occurs in the boundary cycle itself, `value` goes directly into `shown`, and `pend_valid` ends up clear.
- Error override:
  - `error` is sampled every cycle and has no effect on `shown` or `pending`.
  - While high, digits 3,2,1,0 show E,r,r,o. Digits 4 and above are blank.
  - The override removes itself the cycle after `error` falls.
- Ghosting guard: `an` is all-ones whenever `div_cnt` is 0, i.e. the first cycle of each digit slot.

## Timing
- Reset values:
  - `div_cnt` = 0, `digit_idx` = 0.
  - `shown` and `pending` = all 1010 (blank); `pend_valid` = 0.
  - `seg` = 7'b1111111, `an` = all ones, `frame_done` = 0.
- `seg`, `an` and `frame_done` are registered. They reflect `div_cnt`, `digit_idx`, `shown` and `error` from the previous cycle.
- Digit slot = SCAN_DIV cycles, of which SCAN_DIV-1 are lit. Frame = DIGITS*SCAN_DIV cycles.
- `frame_done` is high for exactly one cycle: the cycle after the frame boundary, aligned with `div_cnt` = 0 of digit 0.
- Load-to-display latency: up to one frame plus one cycle. It is never mid-frame, so all digits of one frame come from one `value`.
- Reset asserted mid-frame: everything returns to reset values immediately (asynchronously). The first lit slot after release is digit 0 at cycle 1.

## Configuration
- `DISPLAY_LZS_EN` defined: leading-zero suppression.
  - Any code-0000 digit above the most significant non-zero digit of `shown` displays as blank.
  - Digit 0 is never suppressed. Suppression is not applied under `error`.
  - A non-digit code (1010–1111) counts as non-zero.
- Not defined: all codes are displayed verbatim, and no suppression logic is synthesised.

## Structure
- Package `display_pkg` holds:
  - constants `CODE_BLANK`, `CODE_E`, `CODE_R`, `CODE_O`, `CODE_A`, `CODE_F`;
  - `SEG_OFF` = 7'b1111111;
  - the typedef `seg_t` for the 7-bit segment vector.
- Sub-module `seven_segment_rom`: a purely combinational 4-bit code to active-low `seg_t` lookup, implementing the character code table. It is instantiated once in the output stage.

## Test plan
All scenarios use DIGITS = 4, SCAN_DIV = 4, with `error` low and `DISPLAY_LZS_EN` undefined unless stated.
- Reset, then run 16 cycles:
  - `seg` stays 1111111.
  - `an` cycles 1110, 1101, 1011, 0111, with all-ones on each slot's first cycle.
  - `frame_done` pulses once, at cycle 16.
- Load `value` = 16'h1234 mid-frame: the remaining slots stay blank; the next frame shows digit 0 = 4 (1001100) and digit 3 = 1 (1001111).
- Load 16'h1234, then load 16'h5678 two cycles later in the same frame: the next frame shows 5678 only, never 1234.
- Assert `error` with `shown` = 16'h0042: within 1 cycle, digits 3..0 show 0110000, 1111010, 1111010, 1100010. Deassert: 0042 returns on the next slot.
- With `DISPLAY_LZS_EN` defined, load 16'h0040: digits 3 and 2 are blank, digit 1 = 4, digit 0 = 0 (0000001). Load 16'h0000: only digit 0 is lit, showing 0.
- Assert `reset` mid-slot of digit 2: `seg` and `an` go all-ones immediately; after release, `shown` is blank and the scan restarts at digit 0.
